// File: rtl/rect_cmd_pkg.sv
// Shared constants and types for the rectangle command loader: framing byte,
// packet body length, parser states and body byte offsets.
package rect_cmd_pkg;

    localparam logic [7:0] RC_HEADER   = 8'hA5;
    localparam int         RC_BODY_LEN = 10;

    typedef enum logic [1:0] {
        HUNT,
        BODY,
        CSUM,
        COMMIT
    } rc_state_e;

    typedef logic [3:0] ofs_t;

    localparam ofs_t OFS_IDX   = 4'd0;
    localparam ofs_t OFS_COLOR = 4'd1;
    localparam ofs_t OFS_X1_HI = 4'd2;
    localparam ofs_t OFS_X1_LO = 4'd3;
    localparam ofs_t OFS_X2_HI = 4'd4;
    localparam ofs_t OFS_X2_LO = 4'd5;
    localparam ofs_t OFS_Y1_HI = 4'd6;
    localparam ofs_t OFS_Y1_LO = 4'd7;
    localparam ofs_t OFS_Y2_HI = 4'd8;
    localparam ofs_t OFS_Y2_LO = 4'd9;

endpackage

// File: rtl/rect_cmd_loader.sv
// Parses framed 12-byte rectangle packets from a byte stream, validates checksum,
// bounds and inter-byte timeout, and commits good packets as one config write.
import rect_cmd_pkg::*;

module rect_cmd_loader #(
    parameter int WIDTH      = 800,
    parameter int HEIGHT     = 600,
    parameter int WIDTHBITS  = 10,
    parameter int HEIGHTBITS = 10,
    parameter int COLORBITS  = 8,
    parameter int RECTBITS   = 6,
    parameter int TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [7:0]            cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [COLORBITS-1:0]  st__conf_color,
    output logic                  st__conf_enabled,
    output logic [WIDTHBITS-1:0]  st__conf_rect_x1,
    output logic [WIDTHBITS-1:0]  st__conf_rect_x2,
    output logic [HEIGHTBITS-1:0] st__conf_rect_y1,
    output logic [HEIGHTBITS-1:0] st__conf_rect_y2,
    output logic [RECTBITS-1:0]   vg__rect_index,
    output logic                  vg__rect_write,
    output logic [15:0]           pkt_ok_count,
    output logic                  pkt_err
);

    localparam int                  IDLEBITS   = $clog2(TIMEOUT + 1);
    localparam logic [IDLEBITS-1:0] IDLE_LIMIT = IDLEBITS'(TIMEOUT);
    localparam logic [15:0]         X_LIMIT    = 16'(WIDTH);
    localparam logic [15:0]         Y_LIMIT    = 16'(HEIGHT);

    rc_state_e             state_q, state_d;
    ofs_t                  cnt_q;
    logic [7:0]            csum_q;
    logic [IDLEBITS-1:0]   idle_q;
    logic [7:0]            shadow_q [RC_BODY_LEN];
    logic                  err_q;
    logic [15:0]           ok_cnt_q;
    logic [COLORBITS-1:0]  color_q;
    logic                  en_q;
    logic [WIDTHBITS-1:0]  x1_q, x2_q;
    logic [HEIGHTBITS-1:0] y1_q, y2_q;
    logic [RECTBITS-1:0]   idx_q;

    logic        in_pkt, timeout, accept, pkt_good, commit;
    logic [15:0] x1, x2, y1, y2;

    assign x1 = {shadow_q[OFS_X1_HI], shadow_q[OFS_X1_LO]};
    assign x2 = {shadow_q[OFS_X2_HI], shadow_q[OFS_X2_LO]};
    assign y1 = {shadow_q[OFS_Y1_HI], shadow_q[OFS_Y1_LO]};
    assign y2 = {shadow_q[OFS_Y2_HI], shadow_q[OFS_Y2_LO]};

    assign in_pkt   = (state_q == BODY) || (state_q == CSUM);
    assign timeout  = in_pkt && (idle_q == IDLE_LIMIT);
    assign accept   = cmd_valid && cmd_ready;
    // Checksum and both bounds are judged together so any failure yields one pulse.
    assign pkt_good = (cmd_data == csum_q) && (x1 <= x2) && (x2 < X_LIMIT)
                      && (y1 <= y2) && (y2 < Y_LIMIT);
    assign commit   = (state_q == CSUM) && accept && pkt_good;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= HUNT;
        else        state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (accept && cmd_data == RC_HEADER) state_d = BODY;
            BODY: begin
                if (timeout)                           state_d = HUNT;
                else if (accept && cnt_q == OFS_Y2_LO) state_d = CSUM;
            end
            CSUM: begin
                if (timeout)     state_d = HUNT;
                else if (accept) state_d = pkt_good ? COMMIT : HUNT;
            end
            COMMIT:  state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // The timeout cycle also deasserts ready so the offered byte is not consumed.
    always_comb begin
        cmd_ready      = (state_q != COMMIT) && !timeout;
        vg__rect_write = (state_q == COMMIT);
    end

    // NOTE: the shadow bytes carry no reset; a commit is only reachable after
    // all ten have been rewritten by the current packet.
    always_ff @(posedge clk) begin
        if (state_q == BODY && accept) shadow_q[cnt_q] <= cmd_data;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q    <= '0;
            csum_q   <= '0;
            idle_q   <= '0;
            err_q    <= 1'b0;
            ok_cnt_q <= '0;
            color_q  <= '0;
            en_q     <= 1'b0;
            x1_q     <= '0;
            x2_q     <= '0;
            y1_q     <= '0;
            y2_q     <= '0;
            idx_q    <= '0;
        end else begin
            err_q <= timeout || ((state_q == CSUM) && accept && !pkt_good);

            if (!in_pkt || accept)      idle_q <= '0;
            else if (idle_q != IDLE_LIMIT) idle_q <= idle_q + IDLEBITS'(1);

            if (state_q == HUNT) begin
                cnt_q  <= '0;
                csum_q <= '0;
            end else if (state_q == BODY && accept) begin
                cnt_q  <= cnt_q + 4'd1;
                csum_q <= csum_q ^ cmd_data;
            end

            if (commit) begin
                color_q  <= shadow_q[OFS_COLOR][COLORBITS-1:0];
                en_q     <= shadow_q[OFS_IDX][7];
                idx_q    <= shadow_q[OFS_IDX][RECTBITS-1:0];
                x1_q     <= x1[WIDTHBITS-1:0];
                x2_q     <= x2[WIDTHBITS-1:0];
                y1_q     <= y1[HEIGHTBITS-1:0];
                y2_q     <= y2[HEIGHTBITS-1:0];
                ok_cnt_q <= ok_cnt_q + 16'd1;
            end
        end
    end

    assign st__conf_color   = color_q;
    assign st__conf_enabled = en_q;
    assign st__conf_rect_x1 = x1_q;
    assign st__conf_rect_x2 = x2_q;
    assign st__conf_rect_y1 = y1_q;
    assign st__conf_rect_y2 = y2_q;
    assign vg__rect_index   = idx_q;
    assign pkt_ok_count     = ok_cnt_q;
    assign pkt_err          = err_q;

endmodule

// File: tb/tb_rect_cmd_loader.sv
// Randomized self-checking bench for rect_cmd_loader; expectations come from a
// packet-level model (checksum and bounds rules) plus directed corner cases.
module tb_rect_cmd_loader;

    localparam int WIDTH  = 800;
    localparam int HEIGHT = 600;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  st__conf_color;
    logic        st__conf_enabled;
    logic [9:0]  st__conf_rect_x1, st__conf_rect_x2;
    logic [9:0]  st__conf_rect_y1, st__conf_rect_y2;
    logic [5:0]  vg__rect_index;
    logic        vg__rect_write;
    logic [15:0] pkt_ok_count;
    logic        pkt_err;

    always #5 clk = ~clk;

    rect_cmd_loader #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WIDTHBITS(10), .HEIGHTBITS(10),
        .COLORBITS(8), .RECTBITS(6), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_b(rst_b), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .st__conf_color(st__conf_color),
        .st__conf_enabled(st__conf_enabled), .st__conf_rect_x1(st__conf_rect_x1),
        .st__conf_rect_x2(st__conf_rect_x2), .st__conf_rect_y1(st__conf_rect_y1),
        .st__conf_rect_y2(st__conf_rect_y2), .vg__rect_index(vg__rect_index),
        .vg__rect_write(vg__rect_write), .pkt_ok_count(pkt_ok_count), .pkt_err(pkt_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Committed-state model
    logic [7:0]  m_color = '0;
    logic        m_en    = 1'b0;
    logic [5:0]  m_idx   = '0;
    logic [9:0]  m_x1 = '0, m_x2 = '0, m_y1 = '0, m_y2 = '0;
    logic [15:0] m_ok    = '0;

    task automatic model_reset();
        m_color = '0; m_en = 1'b0; m_idx = '0;
        m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0; m_ok = '0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_color"}, st__conf_color,   m_color);
        check({tag, "_en"},    st__conf_enabled, m_en);
        check({tag, "_idx"},   vg__rect_index,   m_idx);
        check({tag, "_x1"},    st__conf_rect_x1, m_x1);
        check({tag, "_x2"},    st__conf_rect_x2, m_x2);
        check({tag, "_y1"},    st__conf_rect_y1, m_y1);
        check({tag, "_y2"},    st__conf_rect_y2, m_y2);
        check({tag, "_okcnt"}, pkt_ok_count,     m_ok);
    endtask

    // Pulse monitor, sampled on the falling edge
    int   n_wr = 0;
    int   n_err = 0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        if (vg__rect_write) begin
            n_wr++;
            check("ready_low_in_commit", cmd_ready, 1'b0);
        end
        if (pkt_err) begin
            n_err++;
            check("err_single_cycle", prev_err, 1'b0);
        end
        prev_err = pkt_err;
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        cmd_data  = b;
        cmd_valid = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (cmd_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!done) check("handshake_timeout", done, 1'b1);
    endtask

    // mode: 0 back-to-back, 1 one idle cycle between bytes, 2 random 0..3 idle cycles
    task automatic run_pkt(input string tag, input logic [7:0] idx, input logic [7:0] color,
                           input logic [15:0] x1, input logic [15:0] x2,
                           input logic [15:0] y1, input logic [15:0] y2,
                           input logic [7:0] flip, input int mode, input int n_garb);
        logic [7:0] b [12];
        logic [7:0] cs;
        logic [7:0] gb;
        bit         good;
        int         wr0, er0, gap;
        b[0] = 8'hA5; b[1] = idx; b[2] = color;
        b[3] = x1[15:8]; b[4] = x1[7:0]; b[5] = x2[15:8]; b[6] = x2[7:0];
        b[7] = y1[15:8]; b[8] = y1[7:0]; b[9] = y2[15:8]; b[10] = y2[7:0];
        cs = '0;
        for (int i = 1; i <= 10; i++) cs ^= b[i];
        b[11] = cs ^ flip;
        good = (flip == 0) && (x1 <= x2) && (int'(x2) < WIDTH)
               && (y1 <= y2) && (int'(y2) < HEIGHT);
        for (int g = 0; g < n_garb; g++) begin
            gb = 8'($urandom_range(0, 255));
            if (gb == 8'hA5) gb = 8'h5A;
            send_byte(gb, 0);
        end
        wr0 = n_wr;
        er0 = n_err;
        for (int i = 0; i < 12; i++) begin
            gap = (i == 0 || mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
            send_byte(b[i], gap);
        end
        check({tag, "_wr_strobe"},  vg__rect_write, good);
        check({tag, "_err_strobe"}, pkt_err, !good);
        if (good) begin
            m_color = color; m_en = idx[7]; m_idx = idx[5:0];
            m_x1 = x1[9:0]; m_x2 = x2[9:0]; m_y1 = y1[9:0]; m_y2 = y2[9:0];
            m_ok = m_ok + 16'd1;
        end
        @(posedge clk); #1;
        check({tag, "_wr_drop"},  vg__rect_write, 1'b0);
        check({tag, "_err_drop"}, pkt_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_n_wr"},  n_wr - wr0,  good ? 1 : 0);
        check({tag, "_n_err"}, n_err - er0, good ? 0 : 1);
        check_model(tag);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  body [12];
        logic [15:0] x1, x2, y1, y2;
        logic [7:0]  flip;
        int          wr0, er0, kind;
        body = '{8'hA5, 8'h80, 8'hE0, 8'h00, 8'h00, 8'h01, 8'h8F,
                 8'h00, 8'h00, 8'h01, 8'h2B, 8'hC4};

        #12;
        check_model("reset");
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_wr",    vg__rect_write, 1'b0);
        check("reset_err",   pkt_err, 1'b0);
        #5 rst_b = 1'b1;
        @(posedge clk); #1;

        run_pkt("valid", 8'h80, 8'hE0, 16'd0, 16'd399, 16'd0, 16'd299, 8'h00, 0, 0);
        run_pkt("bad_csum", 8'h80, 8'hE0, 16'd0, 16'd399, 16'd0, 16'd299, 8'h01, 0, 0);
        run_pkt("after_bad", 8'h85, 8'h3C, 16'd10, 16'd20, 16'd30, 16'd40, 8'h00, 0, 0);
        run_pkt("x2_800", 8'h81, 8'h11, 16'd0, 16'h0320, 16'd0, 16'd10, 8'h00, 0, 0);
        run_pkt("x1_gt_x2", 8'h81, 8'h11, 16'd10, 16'd5, 16'd0, 16'd10, 8'h00, 0, 0);
        run_pkt("y2_600", 8'h81, 8'h11, 16'd0, 16'd5, 16'd0, 16'd600, 8'h00, 0, 0);
        run_pkt("edge_max", 8'h3F, 8'hFF, 16'd799, 16'd799, 16'd599, 16'd599, 8'h00, 0, 0);

        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h13, 0);
        run_pkt("garbage_toggle", 8'hC7, 8'h5A, 16'd100, 16'd700, 16'd50, 16'd550, 8'h00, 1, 0);

        // Stall after the fifth byte long enough to hit the inter-byte timeout
        wr0 = n_wr;
        er0 = n_err;
        for (int i = 0; i < 5; i++) send_byte(body[i], 0);
        repeat (TMO) @(posedge clk);
        #1;
        check("timeout_ready_low", cmd_ready, 1'b0);
        for (int i = 5; i < 12; i++) send_byte(body[i], 0);
        repeat (3) @(posedge clk);
        #1;
        check("timeout_n_err", n_err - er0, 1);
        check("timeout_n_wr",  n_wr - wr0, 0);
        check_model("timeout");
        run_pkt("after_timeout", 8'h82, 8'h77, 16'd1, 16'd2, 16'd3, 16'd4, 8'h00, 0, 0);

        // Reset pulse in the middle of a packet body
        wr0 = n_wr;
        for (int i = 0; i < 4; i++) send_byte(body[i], 0);
        rst_b = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_wr", n_wr - wr0, 0);
        run_pkt("after_reset", 8'h80, 8'hE0, 16'd0, 16'd399, 16'd0, 16'd299, 8'h00, 0, 0);

        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 9));
            x1 = 16'($urandom_range(0, WIDTH - 1));
            x2 = 16'($urandom_range(int'(x1), WIDTH - 1));
            y1 = 16'($urandom_range(0, HEIGHT - 1));
            y2 = 16'($urandom_range(int'(y1), HEIGHT - 1));
            flip = 8'h00;
            case (kind)
                0: flip = 8'($urandom_range(1, 255));
                1: x2 = 16'($urandom_range(WIDTH, 65535));
                2: y2 = 16'($urandom_range(HEIGHT, 65535));
                3: x1 = x2 + 16'($urandom_range(1, 200));
                4: y1 = y2 + 16'($urandom_range(1, 200));
                default: ;
            endcase
            run_pkt("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    x1, x2, y1, y2, flip, 2, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
